perm_builder: RTL and testbench
===============================

# perm_builder

Parametrised permutation builder for the chaos-based image cipher. Consumes a stream of W-bit chaotic samples, discards values already collected, and appends each first occurrence into an internal permutation memory until all 2^W values are present. An optional fill phase sweeps the occupancy bitmap in ascending order to append any missing values. The completed table is read out through a synchronous port and used as the S-box / pixel-permutation table by the cipher core.

## Interface
- W, default 8: sample width; the permutation has N = 2^W entries (localparam N).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart pulse: empties the bitmap and count, returns to COLLECT.
- in_valid  in  1  sample valid.
- in_data  in  W  chaotic sample.
- in_ready  out  1  high only in COLLECT.
- fill_start  in  1  pulse: begin ascending fill of missing values.
- out_valid  out  1  one-cycle pulse per accepted sample.
- out_dup  out  1  accepted sample was already present; qualified by out_valid.
- out_index  out  W  table index the sample was written to; holds the current count when out_dup=1.
- count  out  W+1  number of entries written, 0..N.
- done  out  1  high in DONE, when count == N.
- rd_addr  in  W  readout index.
- rd_data  out  W  table[rd_addr], one cycle later.

## Operation
- States: COLLECT (reset state), FILL, DONE.
- COLLECT: on accept (in_valid && in_ready), if bitmap[in_data]==0: write table[count]=in_data, set the bit, increment count. Otherwise the table is unchanged and out_dup=1.
- Value 0 is an ordinary value. An empty bitmap never flags a duplicate.
- COLLECT -> DONE at the edge where count becomes N. COLLECT -> FILL on fill_start while count<N. fill_start while count==N goes straight to DONE.
- FILL: pointer p starts at 0 and advances by 1 per cycle. If bitmap[p]==0: write table[count]=p, set the bit, increment count. FILL -> DONE at the edge where count becomes N. At most N cycles.
- DONE: holds until clear or reset. in_ready=0. The table stays readable.
- Priority: reset > clear > all else.
  - clear returns to COLLECT with count=0 and bitmap=0. Table contents are left stale.
  - fill_start is ignored in FILL and DONE.
  - fill_start together with an accepted sample: the sample is processed at that edge and FILL begins the next cycle.
- rd_data for rd_addr >= count is don't-care.

## Timing
- Reset values: state COLLECT, count 0, bitmap 0, out_valid 0, out_dup 0, out_index 0, done 0, rd_data 0, p 0. in_ready is 1 after reset is released.
- in_ready is combinational from the state only; it does not depend on in_valid.
- The bitmap, table and count update at the accepting edge. out_valid, out_dup and out_index are registered and appear on the following cycle.
- A duplicate arriving on the very next cycle is flagged correctly, with no hazard window.
- done rises the cycle after the edge that writes the Nth entry. in_ready falls on that same cycle.
- Readout latency: 1 cycle. Reads are legal in any state, including during writes. A same-cycle write to the same address returns the old data.
- clear or reset mid-FILL aborts immediately. p returns to 0.

## Structure
- perm_pkg holds:
  - the state enum typedef (COLLECT, FILL, DONE);
  - a function computing N from W.
- Bitmap: a flat N-bit register vector, cleared in one cycle. No CAM search.
- Sub-module perm_ram:
  - N x W;
  - one write port, one synchronous read port;
  - no reset on contents.

## Test plan
- W=4, reset, feed 0,0,5,0 -> out_dup 0,1,0,1; out_index 0,1,1,2; count=2. table[0]=0, table[1]=5.
- W=4, feed 15,14,...,0 back-to-back -> no duplicates, count=16, done=1. in_ready drops the cycle after the 16th accept. rd_addr=3 -> rd_data=12 one cycle later.
- W=4, feed 3,7, then fill_start -> FILL appends 0,1,2,4,5,6,8..15. done after 16 FILL cycles (p reaches 15). table = 3,7,0,1,2,4,5,6,8,...,15.
- W=4, fill_start while accepting 9 -> table[0]=9, then fill appends 0..8 and 10..15.
- clear pulsed mid-FILL, then feed 2 -> count=1, table[0]=2, out_dup=0.
- rst_n asserted asynchronously mid-COLLECT -> every output takes its reset value without a clock edge. Refeeding earlier values afterwards gives out_dup=0.

Source files
------------

// File: rtl/perm_pkg.sv
// Shared types and sizing helpers for the chaos-cipher permutation builder.
package perm_pkg;

  typedef enum logic [1:0] {
    StCollect,
    StFill,
    StDone
  } perm_state_e;

  // Number of table entries for a W-bit sample width.
  function automatic int unsigned perm_entries(int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/perm_builder_if.sv
// Sample stream, control and readout bundle of perm_builder.
interface perm_builder_if #(
  parameter int unsigned W = 8
);
  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         fill_start;
  logic         out_valid;
  logic         out_dup;
  logic [W-1:0] out_index;
  logic [W:0]   count;
  logic         done;
  logic [W-1:0] rd_addr;
  logic [W-1:0] rd_data;

  modport master (
    output clear, in_valid, in_data, fill_start, rd_addr,
    input  in_ready, out_valid, out_dup, out_index, count, done, rd_data
  );

  modport slave (
    input  clear, in_valid, in_data, fill_start, rd_addr,
    output in_ready, out_valid, out_dup, out_index, count, done, rd_data
  );
endinterface

// File: rtl/perm_ram.sv
// N x W permutation table: one write port, one registered read port.
module perm_ram
  import perm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] rd_addr,
  output logic [W-1:0] rd_data
);
  localparam int unsigned N = perm_entries(W);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register samples the array before a same-edge write lands: old data wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/perm_builder.sv
// Collects first occurrences of chaotic samples into a permutation table,
// with an optional ascending fill of the values never seen.
module perm_builder
  import perm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic           clk,
  input logic           rst_n,
  perm_builder_if.slave bus
);
  localparam int unsigned N = perm_entries(W);
  localparam logic [W:0] CountFull = (W + 1)'(N);

  perm_state_e  state_q;
  logic [W:0]   count_q;
  logic [N-1:0] bitmap_q;
  logic [W-1:0] p_q;
  logic         out_valid_q;
  logic         out_dup_q;
  logic [W-1:0] out_index_q;
  logic         done_q;

  logic         accept;
  logic         is_dup;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic [W:0]   count_inc;
  logic         reach_full;

  assign bus.in_ready  = (state_q == StCollect);
  assign bus.out_valid = out_valid_q;
  assign bus.out_dup   = out_dup_q;
  assign bus.out_index = out_index_q;
  assign bus.count     = count_q;
  assign bus.done      = done_q;

  assign count_inc  = count_q + 1'b1;
  assign reach_full = wr_en && (count_inc == CountFull);

  // Bitmap is read combinationally and set at the same edge, so a repeat on the
  // very next cycle already sees the bit.
  always_comb begin
    accept  = 1'b0;
    is_dup  = 1'b0;
    wr_en   = 1'b0;
    wr_data = bus.in_data;
    if (!bus.clear) begin
      case (state_q)
        StCollect: begin
          if (bus.in_valid) begin
            accept = 1'b1;
            is_dup = bitmap_q[bus.in_data];
            wr_en  = !is_dup;
          end
        end
        StFill: begin
          wr_data = p_q;
          wr_en   = !bitmap_q[p_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      count_q     <= '0;
      bitmap_q    <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_dup_q   <= 1'b0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else if (bus.clear) begin
      state_q     <= StCollect;
      count_q     <= '0;
      bitmap_q    <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_dup_q   <= 1'b0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= accept;
      out_dup_q   <= accept && is_dup;
      if (accept) begin
        out_index_q <= count_q[W-1:0];
      end
      if (wr_en) begin
        bitmap_q[wr_data] <= 1'b1;
        count_q           <= count_inc;
      end
      case (state_q)
        StCollect: begin
          if (reach_full || (bus.fill_start && count_q == CountFull)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (bus.fill_start) begin
            state_q <= StFill;
            p_q     <= '0;
          end
        end
        StFill: begin
          p_q <= p_q + 1'b1;
          if (reach_full) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  perm_ram #(
    .W(W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(count_q[W-1:0]),
    .wr_data(wr_data),
    .rd_addr(bus.rd_addr),
    .rd_data(bus.rd_data)
  );

endmodule

// File: tb/tb_perm_builder.sv
// Directed bench for perm_builder at W=4.
module tb_perm_builder;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  perm_builder_if #(.W(4)) bus ();

  perm_builder #(
    .W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 6;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got %0d want 0", bus.count); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_index !== 4'd0) begin failures++; $display("FAIL reset_out_index got %0d want 0", bus.out_index); end
    if (bus.rd_data !== 4'd0) begin failures++; $display("FAIL reset_rd_data got %0d want 0", bus.rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dup();
    logic [3:0] d   [4] = '{4'd0, 4'd0, 4'd5, 4'd0};
    logic       dup [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] idx [4] = '{4'd0, 4'd1, 4'd1, 4'd2};
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL dup_valid[%0d] got %b want 1", i, bus.out_valid); end
      if (bus.out_dup !== dup[i]) begin failures++; $display("FAIL dup_flag[%0d] got %b want %b", i, bus.out_dup, dup[i]); end
      if (bus.out_index !== idx[i]) begin failures++; $display("FAIL dup_index[%0d] got %0d want %0d", i, bus.out_index, idx[i]); end
      if (i < 3) bus.in_data = d[i+1];
      else bus.in_valid = 1'b0;
    end
    checks++;
    if (bus.count !== 5'd2) begin failures++; $display("FAIL dup_count got %0d want 2", bus.count); end
    bus.rd_addr = 4'd0;
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 4'd0) begin failures++; $display("FAIL dup_table0 got %0d want 0", bus.rd_data); end
    bus.rd_addr = 4'd1;
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 4'd5) begin failures++; $display("FAIL dup_table1 got %0d want 5", bus.rd_data); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd15;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ei;
      logic       er;
      ei = 4'(i);
      er = (i < 15);
      @(negedge clk);
      checks += 4;
      if (bus.out_dup !== 1'b0) begin failures++; $display("FAIL b2b_dup[%0d] got %b want 0", i, bus.out_dup); end
      if (bus.out_index !== ei) begin failures++; $display("FAIL b2b_index[%0d] got %0d want %0d", i, bus.out_index, ei); end
      if (bus.in_ready !== er) begin failures++; $display("FAIL b2b_ready[%0d] got %b want %b", i, bus.in_ready, er); end
      if (bus.done !== !er) begin failures++; $display("FAIL b2b_done[%0d] got %b want %b", i, bus.done, !er); end
      if (i < 15) bus.in_data = 4'(14 - i);
      else bus.in_valid = 1'b0;
    end
    checks++;
    if (bus.count !== 5'd16) begin failures++; $display("FAIL b2b_count got %0d want 16", bus.count); end
    bus.rd_addr    = 4'd3;
    bus.fill_start = 1'b1;
    @(negedge clk);
    bus.fill_start = 1'b0;
    checks += 2;
    if (bus.rd_data !== 4'd12) begin failures++; $display("FAIL b2b_read3 got %0d want 12", bus.rd_data); end
    if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_fill_in_done got %b want 1", bus.done); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_tab [16];
    int         cycles;
    int         k;
    exp_tab[0] = 4'd3;
    exp_tab[1] = 4'd7;
    k = 2;
    for (int v = 0; v < 16; v++) begin
      if (v != 3 && v != 7) begin
        exp_tab[k] = 4'(v);
        k++;
      end
    end
    do_clear();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd3;
    @(negedge clk);
    bus.in_data = 4'd7;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.fill_start = 1'b1;
    @(negedge clk);
    bus.fill_start = 1'b0;
    checks += 2;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got %b want 0", bus.in_ready); end
    if (bus.count !== 5'd2) begin failures++; $display("FAIL fill_start_count got %0d want 2", bus.count); end
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != 16) begin failures++; $display("FAIL fill_cycles got %0d want 16", cycles); end
    bus.rd_addr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rd_data !== exp_tab[i]) begin failures++; $display("FAIL fill_table[%0d] got %0d want %0d", i, bus.rd_data, exp_tab[i]); end
      bus.rd_addr = 4'(i + 1);
    end
  endtask

  task automatic test_fill_with_sample();
    logic [3:0] exp_tab [16];
    int         cycles;
    int         k;
    exp_tab[0] = 4'd9;
    k = 1;
    for (int v = 0; v < 16; v++) begin
      if (v != 9) begin
        exp_tab[k] = 4'(v);
        k++;
      end
    end
    do_clear();
    bus.in_valid   = 1'b1;
    bus.in_data    = 4'd9;
    bus.fill_start = 1'b1;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.fill_start = 1'b0;
    checks += 3;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL fws_valid got %b want 1", bus.out_valid); end
    if (bus.out_dup !== 1'b0) begin failures++; $display("FAIL fws_dup got %b want 0", bus.out_dup); end
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fws_ready got %b want 0", bus.in_ready); end
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != 16) begin failures++; $display("FAIL fws_cycles got %0d want 16", cycles); end
    bus.rd_addr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rd_data !== exp_tab[i]) begin failures++; $display("FAIL fws_table[%0d] got %0d want %0d", i, bus.rd_data, exp_tab[i]); end
      bus.rd_addr = 4'(i + 1);
    end
  endtask

  task automatic test_clear_mid_fill();
    do_clear();
    bus.fill_start = 1'b1;
    @(negedge clk);
    bus.fill_start = 1'b0;
    repeat (5) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    checks += 3;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL cmf_ready got %b want 1", bus.in_ready); end
    if (bus.count !== 5'd0) begin failures++; $display("FAIL cmf_count0 got %0d want 0", bus.count); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL cmf_done got %b want 0", bus.done); end
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd2;
    bus.rd_addr  = 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks += 4;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL cmf_valid got %b want 1", bus.out_valid); end
    if (bus.out_dup !== 1'b0) begin failures++; $display("FAIL cmf_dup got %b want 0", bus.out_dup); end
    if (bus.out_index !== 4'd0) begin failures++; $display("FAIL cmf_index got %0d want 0", bus.out_index); end
    if (bus.count !== 5'd1) begin failures++; $display("FAIL cmf_count got %0d want 1", bus.count); end
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 4'd2) begin failures++; $display("FAIL cmf_table0 got %0d want 2", bus.rd_data); end
  endtask

  task automatic test_async_reset();
    do_clear();
    bus.rd_addr  = 4'd0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd1;
    @(negedge clk);
    bus.in_data = 4'd2;
    @(posedge clk);
    #2;
    checks += 3;
    if (bus.count !== 5'd2) begin failures++; $display("FAIL ar_pre_count got %0d want 2", bus.count); end
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got %b want 1", bus.out_valid); end
    if (bus.rd_data !== 4'd1) begin failures++; $display("FAIL ar_pre_rd got %0d want 1", bus.rd_data); end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (bus.count !== 5'd0) begin failures++; $display("FAIL ar_count got %0d want 0", bus.count); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got %b want 0", bus.out_valid); end
    if (bus.out_index !== 4'd0) begin failures++; $display("FAIL ar_index got %0d want 0", bus.out_index); end
    if (bus.out_dup !== 1'b0) begin failures++; $display("FAIL ar_dup got %b want 0", bus.out_dup); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL ar_done got %b want 0", bus.done); end
    if (bus.rd_data !== 4'd0) begin failures++; $display("FAIL ar_rd got %0d want 0", bus.rd_data); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd1;
    @(negedge clk);
    bus.in_data = 4'd2;
    checks += 2;
    if (bus.out_dup !== 1'b0) begin failures++; $display("FAIL ar_refeed1_dup got %b want 0", bus.out_dup); end
    if (bus.out_index !== 4'd0) begin failures++; $display("FAIL ar_refeed1_index got %0d want 0", bus.out_index); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.out_dup !== 1'b0) begin failures++; $display("FAIL ar_refeed2_dup got %b want 0", bus.out_dup); end
    if (bus.out_index !== 4'd1) begin failures++; $display("FAIL ar_refeed2_index got %0d want 1", bus.out_index); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.clear      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.fill_start = 1'b0;
    bus.rd_addr    = '0;
    test_reset();
    test_dup();
    test_back_to_back();
    test_fill();
    test_fill_with_sample();
    test_clear_mid_fill();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
